// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak-bin finder.
//   FFT_N_LOG2 / FFT_DW / FFT_PW : default frame size (log2), sample width, power width
//   frame_state_e                : frame-assembly FSM states
//   pipe_tag_t                   : side-band tag that travels with each sample through the pipe
package fft_pkg;

    localparam int unsigned FFT_N_LOG2 = 6;
    localparam int unsigned FFT_DW     = 16;
    localparam int unsigned FFT_PW     = 2 * FFT_DW;

    typedef enum logic [0:0] {
        StIdle,
        StAcc
    } frame_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  first;
        logic                  last;
        logic [FFT_N_LOG2-1:0] bin;
    } pipe_tag_t;

    localparam pipe_tag_t TagNone = '0;

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage registered squared magnitude |z|^2 = re^2 + im^2 with pass-through tags.
//   clk_i  : rising-edge clock
//   rst_i  : synchronous active-high reset; clears tags and data
//   tag_i  : tag of the incoming sample
//   re_i   : signed real part
//   im_i   : signed imaginary part
//   tag_o  : tag aligned with pow_o (two cycles after tag_i)
//   pow_o  : unsigned re^2 + im^2
module cplx_mag_sq
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW,
    parameter int unsigned PW = FFT_PW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  pipe_tag_t            tag_i,
    input  logic signed [DW-1:0] re_i,
    input  logic signed [DW-1:0] im_i,
    output pipe_tag_t            tag_o,
    output logic        [PW-1:0] pow_o
);

    pipe_tag_t                 tag1_q;
    pipe_tag_t                 tag2_q;
    logic signed [2*DW-1:0]    re_sq_d;
    logic signed [2*DW-1:0]    im_sq_d;
    logic signed [2*DW-1:0]    re_sq_q;
    logic signed [2*DW-1:0]    im_sq_q;
    logic        [PW-1:0]      pow_d;
    logic        [PW-1:0]      pow_q;

    // Sign-extend before multiplying so the full 2*DW product is kept.
    always_comb begin
        re_sq_d = (2 * DW)'(re_i) * (2 * DW)'(re_i);
        im_sq_d = (2 * DW)'(im_i) * (2 * DW)'(im_i);
    end

    // Squares are never negative, so treating them as unsigned is exact.
    // Worst case 2 * 2**(2*DW-2) = 2**(2*DW-1) still fits in PW bits.
    always_comb begin
        pow_d = PW'($unsigned(re_sq_q)) + PW'($unsigned(im_sq_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag1_q  <= TagNone;
            tag2_q  <= TagNone;
            re_sq_q <= '0;
            im_sq_q <= '0;
            pow_q   <= '0;
        end else begin
            tag1_q  <= tag_i;
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            tag2_q  <= tag1_q;
            pow_q   <= pow_d;
        end
    end

    assign tag_o = tag2_q;
    assign pow_o = pow_q;

endmodule

// File: rtl/fft_peak_bin_finder.sv
// Finds the strongest bin of each FFT frame streamed out of a pipelined FFT core.
//   clk_i        : rising-edge clock
//   areset_i     : synchronous active-high reset
//   din_en_i     : bin valid
//   din_cnt_i    : bin index of the current sample (any order)
//   din_re_i     : signed real part
//   din_im_i     : signed imaginary part
//   peak_valid_o : one-cycle pulse, frame result ready
//   peak_bin_o   : index of the strongest bin, held until next peak_valid_o
//   peak_pow_o   : re^2 + im^2 of peak_bin_o, held until next peak_valid_o
//   frame_err_o  : one-cycle pulse, sample dropped or frame aborted
module fft_peak_bin_finder
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2  = FFT_N_LOG2,
    parameter int unsigned DW      = FFT_DW,
    parameter int unsigned PW      = 2 * DW,
    parameter bit          SKIP_DC = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 areset_i,
    input  logic                 din_en_i,
    input  logic [N_LOG2-1:0]    din_cnt_i,
    input  logic signed [DW-1:0] din_re_i,
    input  logic signed [DW-1:0] din_im_i,
    output logic                 peak_valid_o,
    output logic [N_LOG2-1:0]    peak_bin_o,
    output logic [PW-1:0]        peak_pow_o,
    output logic                 frame_err_o
);

    localparam logic [N_LOG2-1:0] LastCnt = '1;

    // ------------------------------------------------------------------
    // Frame-assembly FSM
    // ------------------------------------------------------------------
    frame_state_e        state_q, state_d;
    logic [N_LOG2-1:0]   cnt_q, cnt_d;
    logic                cnt_is_zero;
    logic                accept;
    logic                is_first;
    logic                is_last;
    logic                err_d;
    pipe_tag_t           tag_in;

    assign cnt_is_zero = (din_cnt_i == '0);

    always_ff @(posedge clk_i) begin
        if (areset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (din_en_i && cnt_is_zero) begin
                    state_d = StAcc;
                    cnt_d   = N_LOG2'(1);
                end
            end
            StAcc: begin
                if (din_en_i) begin
                    if (cnt_is_zero) begin
                        // Premature bin 0 restarts the frame with this sample.
                        cnt_d = N_LOG2'(1);
                    end else if (cnt_q == LastCnt) begin
                        // Back to idle on the same edge so the next bin 0 is taken at once.
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + N_LOG2'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        is_first = 1'b0;
        is_last  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                accept = din_en_i && cnt_is_zero;
                err_d  = din_en_i && !cnt_is_zero;
            end
            StAcc: begin
                accept  = din_en_i;
                err_d   = din_en_i && cnt_is_zero;
                is_last = din_en_i && !cnt_is_zero && (cnt_q == LastCnt);
            end
        endcase
        // Every accepted bin 0 opens a frame, in either state.
        is_first = accept && cnt_is_zero;

        tag_in       = TagNone;
        tag_in.valid = accept;
        tag_in.first = is_first;
        tag_in.last  = is_last;
        tag_in.bin   = din_cnt_i;
    end

    // ------------------------------------------------------------------
    // S1 / S2: squared magnitude
    // ------------------------------------------------------------------
    pipe_tag_t    tag_s2;
    logic [PW-1:0] pow_s2;

    cplx_mag_sq #(
        .DW (DW),
        .PW (PW)
    ) u_mag_sq (
        .clk_i (clk_i),
        .rst_i (areset_i),
        .tag_i (tag_in),
        .re_i  (din_re_i),
        .im_i  (din_im_i),
        .tag_o (tag_s2),
        .pow_o (pow_s2)
    );

    // ------------------------------------------------------------------
    // S3: running maximum, then result register
    // ------------------------------------------------------------------
    logic [PW-1:0]     max_q, max_d;
    logic [N_LOG2-1:0] max_bin_q, max_bin_d;
    logic              done_q;
    logic              is_dc;
    logic              wins;
    logic              peak_valid_q;
    logic [N_LOG2-1:0] peak_bin_q;
    logic [PW-1:0]     peak_pow_q;
    logic              frame_err_q;

    assign is_dc = SKIP_DC && (tag_s2.bin == '0);

    // Ties go to the lower index so the result does not depend on arrival order.
    assign wins = (pow_s2 > max_q) || ((pow_s2 == max_q) && (tag_s2.bin < max_bin_q));

    always_comb begin
        max_d     = max_q;
        max_bin_d = max_bin_q;
        if (tag_s2.valid) begin
            if (tag_s2.first) begin
                if (is_dc) begin
                    max_d     = '0;
                    max_bin_d = '0;
                end else begin
                    max_d     = pow_s2;
                    max_bin_d = tag_s2.bin;
                end
            end else if (!is_dc && wins) begin
                max_d     = pow_s2;
                max_bin_d = tag_s2.bin;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (areset_i) begin
            max_q        <= '0;
            max_bin_q    <= '0;
            done_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_pow_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            max_q        <= max_d;
            max_bin_q    <= max_bin_d;
            done_q       <= tag_s2.valid && tag_s2.last;
            peak_valid_q <= done_q;
            frame_err_q  <= err_d;
            // max_q here already includes the frame's last sample.
            if (done_q) begin
                peak_bin_q <= max_bin_q;
                peak_pow_q <= max_q;
            end
        end
    end

    assign peak_valid_o = peak_valid_q;
    assign peak_bin_o   = peak_bin_q;
    assign peak_pow_o   = peak_pow_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_bin_finder.sv
module tb_fft_peak_bin_finder;

    localparam int NL = 6;
    localparam int DW = 16;
    localparam int PW = 32;
    localparam int NB = 64;
    localparam bit SKIP = 1'b1;

    logic          clk;
    logic          areset;
    logic          din_en;
    logic [NL-1:0] din_cnt;
    logic [DW-1:0] din_re;
    logic [DW-1:0] din_im;
    logic          peak_valid;
    logic [NL-1:0] peak_bin;
    logic [PW-1:0] peak_pow;
    logic          frame_err;

    fft_peak_bin_finder #(
        .N_LOG2  (NL),
        .DW      (DW),
        .PW      (PW),
        .SKIP_DC (SKIP)
    ) dut (
        .clk_i        (clk),
        .areset_i     (areset),
        .din_en_i     (din_en),
        .din_cnt_i    (din_cnt),
        .din_re_i     (din_re),
        .din_im_i     (din_im),
        .peak_valid_o (peak_valid),
        .peak_bin_o   (peak_bin),
        .peak_pow_o   (peak_pow),
        .frame_err_o  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, edge_n);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: collects each frame's (bin, power) list and, when the
    // frame closes, picks the strongest eligible bin.
    // ------------------------------------------------------------------
    typedef struct {
        int     bin;
        longint pow;
    } samp_t;

    samp_t  frame_q[$];
    bit     m_acc = 1'b0;
    int     m_cnt = 0;
    samp_t  exp_res[int];   // keyed by edge after which peak_valid is high
    bit     exp_err[int];
    bit     exp_rst[int];

    function automatic samp_t frame_peak();
        samp_t best;
        bit    found;
        best.bin = 0;
        best.pow = 0;
        found    = 1'b0;
        foreach (frame_q[i]) begin
            // With DC skipping only non-DC bins with real energy can be reported.
            if (SKIP && (frame_q[i].bin == 0 || frame_q[i].pow == 0)) continue;
            if (!found || frame_q[i].pow > best.pow ||
                (frame_q[i].pow == best.pow && frame_q[i].bin < best.bin)) begin
                best  = frame_q[i];
                found = 1'b1;
            end
        end
        return best;
    endfunction

    function automatic void model_edge(bit en, int cnt, int re, int im, int e);
        samp_t s;
        if (!en) return;
        if (!m_acc && cnt != 0) begin
            exp_err[e] = 1'b1;
            return;
        end
        if (m_acc && cnt == 0) exp_err[e] = 1'b1;
        if (cnt == 0) begin
            frame_q.delete();
            m_cnt = 0;
            m_acc = 1'b1;
        end
        s.bin = cnt;
        s.pow = longint'(re) * re + longint'(im) * im;
        frame_q.push_back(s);
        m_cnt++;
        if (m_cnt == NB) begin
            exp_res[e + 3] = frame_peak();
            m_acc = 1'b0;
            m_cnt = 0;
        end
    endfunction

    function automatic void model_reset(int e);
        int ks[$];
        exp_rst[e] = 1'b1;
        foreach (exp_res[k]) if (k >= e) ks.push_back(k);
        foreach (ks[i]) exp_res.delete(ks[i]);
        ks.delete();
        foreach (exp_err[k]) if (k >= e) ks.push_back(k);
        foreach (ks[i]) exp_err.delete(ks[i]);
        frame_q.delete();
        m_acc = 1'b0;
        m_cnt = 0;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare
    // ------------------------------------------------------------------
    int     hold_bin = 0;
    longint hold_pow = 0;
    int     pv_seen  = 0;
    int     err_seen = 0;
    int     pv_edges[$];

    always @(negedge clk) begin
        int e;
        if (chk_en) begin
            e = edge_n;
            if (exp_rst.exists(e)) begin
                hold_bin = 0;
                hold_pow = 0;
            end
            if (exp_res.exists(e)) begin
                hold_bin = exp_res[e].bin;
                hold_pow = exp_res[e].pow;
            end
            check("peak_valid", 64'(peak_valid), 64'(exp_res.exists(e)));
            check("frame_err",  64'(frame_err),  64'(exp_err.exists(e)));
            check("peak_bin",   64'(peak_bin),   64'(hold_bin));
            check("peak_pow",   64'(peak_pow),   64'(hold_pow));
            if (peak_valid === 1'b1) begin
                pv_seen++;
                pv_edges.push_back(e);
            end
            if (frame_err === 1'b1) err_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int fre[NB];
    int fim[NB];
    int ord[NB];

    task automatic drive(input bit en, input int cnt, input int re, input int im);
        din_en  = en;
        din_cnt = NL'(cnt);
        din_re  = DW'(re);
        din_im  = DW'(im);
        model_edge(en, cnt, re, im, edge_n + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            areset = 1'b1;
            din_en = 1'b0;
            model_reset(edge_n + 1);
            @(posedge clk);
            #1;
        end
        areset = 1'b0;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NB; i++) begin
            fre[i] = 0;
            fim[i] = 0;
            ord[i] = i;
        end
    endtask

    function automatic int brev(input int i);
        logic [NL-1:0] x;
        logic [NL-1:0] r;
        x = NL'(i);
        for (int j = 0; j < NL; j++) r[j] = x[NL-1-j];
        return int'(r);
    endfunction

    // gap > 0 inserts an idle cycle after every gap-th sample
    task automatic play(input int gap);
        for (int i = 0; i < NB; i++) begin
            drive(1'b1, ord[i], fre[ord[i]], fim[ord[i]]);
            if (gap > 0 && (i % gap) == gap - 1) idle(1);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int k;
        int pv0;
        int err0;
        areset  = 1'b1;
        din_en  = 1'b0;
        din_cnt = '0;
        din_re  = '0;
        din_im  = '0;
        chk_en  = 1'b1;
        do_reset(2);

        check("rst_peak_valid", 64'(peak_valid), 64'd0);
        check("rst_peak_bin",   64'(peak_bin),   64'd0);
        check("rst_peak_pow",   64'(peak_pow),   64'd0);
        check("rst_frame_err",  64'(frame_err),  64'd0);

        // Natural order, single peak.
        clear_frame();
        fre[5] = 1000;
        pv0  = pv_seen;
        err0 = err_seen;
        play(0);
        k = edge_n;
        idle(6);
        check("t1_pv_count", 64'(pv_seen - pv0), 64'd1);
        check("t1_latency",  64'(pv_edges[$] - k), 64'd3);
        check("t1_bin",      64'(peak_bin), 64'd5);
        check("t1_pow",      64'(peak_pow), 64'd1000000);
        check("t1_no_err",   64'(err_seen - err0), 64'd0);

        // Bit-reversed order, extreme negative values.
        clear_frame();
        for (int i = 0; i < NB; i++) begin
            fre[i] = i % 7;
            fim[i] = -(i % 5);
            ord[i] = brev(i);
        end
        fre[12] = -32768;
        fim[12] = -32768;
        play(0);
        idle(6);
        check("t2_bin", 64'(peak_bin), 64'd12);
        check("t2_pow", 64'(peak_pow), 64'd2147483648);

        // DC skip and tie to lower index (bin 9 arrives before bin 3).
        clear_frame();
        fre[0] = 30000;
        fre[9] = 100;
        fre[3] = 100;
        for (int i = 1; i < NB; i++) ord[i] = NB - i;
        play(0);
        idle(6);
        check("t3_bin", 64'(peak_bin), 64'd3);
        check("t3_pow", 64'(peak_pow), 64'd10000);

        // Stray sample in idle, then an aborted frame, with gaps.
        pv0  = pv_seen;
        err0 = err_seen;
        drive(1'b1, 7, 999, 0);
        idle(2);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i, (i == 10) ? 20000 : 0, 0);
            if (i % 3 == 2) idle(1);
        end
        clear_frame();
        fre[50] = 500;
        play(3);
        idle(6);
        check("t4_err_count", 64'(err_seen - err0), 64'd2);
        check("t4_pv_count",  64'(pv_seen - pv0),   64'd1);
        check("t4_bin",       64'(peak_bin), 64'd50);
        check("t4_pow",       64'(peak_pow), 64'd250000);

        // Back-to-back frames with no bubble.
        pv0 = pv_seen;
        clear_frame();
        fre[40] = -3000;
        fim[40] = 4000;
        play(0);
        clear_frame();
        fre[2] = 7;
        fim[2] = -24;
        play(0);
        idle(6);
        check("t5_pv_count", 64'(pv_seen - pv0), 64'd2);
        check("t5_spacing",  64'(pv_edges[$] - pv_edges[$-1]), 64'd64);
        check("t5_bin",      64'(peak_bin), 64'd2);
        check("t5_pow",      64'(peak_pow), 64'd625);

        // Reset in the middle of a frame.
        pv0 = pv_seen;
        for (int i = 0; i < 30; i++) drive(1'b1, i, (i == 20) ? 9000 : 0, 0);
        areset  = 1'b1;
        din_en  = 1'b1;
        din_cnt = NL'(30);
        model_reset(edge_n + 1);
        @(posedge clk);
        #1;
        areset = 1'b0;
        din_en = 1'b0;
        check("t6_rst_bin", 64'(peak_bin), 64'd0);
        check("t6_rst_pow", 64'(peak_pow), 64'd0);
        idle(6);
        check("t6_no_pv", 64'(pv_seen - pv0), 64'd0);
        clear_frame();
        fre[63] = 1;
        fim[63] = 1;
        play(0);
        idle(6);
        check("t6_bin", 64'(peak_bin), 64'd63);
        check("t6_pow", 64'(peak_pow), 64'd2);

        // All-zero frame reports bin 0 with zero power.
        pv0 = pv_seen;
        clear_frame();
        play(0);
        idle(6);
        check("t7_pv_count", 64'(pv_seen - pv0), 64'd1);
        check("t7_bin",      64'(peak_bin), 64'd0);
        check("t7_pow",      64'(peak_pow), 64'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_peak_bin_finder.md
Name: fft_peak_bin_finder

Overview:
- Sits directly downstream of corefft (64-point radix-2 pipelined FFT) and consumes its output stream: dout_en, dout_cnt, dout_re, dout_im.
- Computes squared magnitude per bin through a 3-stage pipeline.
- Tracks the strongest bin of each 64-bin frame and reports its index and power once per frame.
- Feeds the spectrum-monitor / control logic.

Parameters:
- N_LOG2, 6, log2 of FFT length; frame = 2**N_LOG2 bins.
- DW, 16, signed width of din_re and din_im.
- PW, 2*DW, unsigned width of peak_pow; holds up to 2**(2*DW-1).
- SKIP_DC, 1, when 1, bin 0 is counted but excluded from the peak search.

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  synchronous, active-high reset.
- din_en  in  1  bin valid; connects to corefft dout_en.
- din_cnt  in  N_LOG2  bin index of the current sample, any order; connects to dout_cnt.
- din_re  in  DW  signed real part.
- din_im  in  DW  signed imaginary part.
- peak_valid  out  1  one-cycle pulse: frame result ready.
- peak_bin  out  N_LOG2  index of the strongest bin; held until the next peak_valid.
- peak_pow  out  PW  re^2+im^2 of peak_bin; held until the next peak_valid.
- frame_err  out  1  one-cycle pulse: sample dropped or frame aborted.

Behaviour:
- Reset (areset=1 at an edge): all outputs 0, state IDLE, sample counter 0, pipeline valid/first/last tags cleared. Reset takes effect mid-frame: the partial frame is discarded and no peak_valid is issued for it.
- A sample is accepted when din_en=1 at a rising edge, subject to the FSM rules below.
- IDLE state:
  - din_en=1 with din_cnt==0: accept, tag first, counter=1, go to ACC.
  - din_en=1 with din_cnt!=0: drop the sample, pulse frame_err the next cycle, stay in IDLE.
- ACC state:
  - din_en=1 with din_cnt!=0: accept, counter+1.
  - din_en=0 cycles are gaps: the frame pauses and nothing is lost.
  - Accepted sample with counter==2**N_LOG2-1: tag last, counter=0, go to IDLE in the same edge. A new frame's bin 0 on the very next cycle is accepted, so back-to-back frames have zero bubble.
  - din_en=1 with din_cnt==0 before the frame is complete: pulse frame_err, discard the partial frame, accept this sample as first of a new frame, counter=1.
- Duplicate or missing non-zero indices are not checked; exactly 2**N_LOG2 accepted samples close a frame.
- Pipeline (each stage carries valid, first, last and bin tags):
  - S1: register re*re and im*im, both signed DW x DW.
  - S2: register pow = unsigned sum, PW bits. Maximum case is (-32768)^2*2 = 2**31, with no overflow.
  - S3: running maximum update:
    - If first: load max=pow, maxbin=bin; if SKIP_DC and bin==0, load max=0, maxbin=0 instead.
    - Otherwise replace when pow>max, or when pow==max and bin<maxbin (tie goes to the lower index, independent of arrival order).
    - Bin 0 never replaces when SKIP_DC=1.
    - If last: after the update, drive peak_bin/peak_pow from the post-update max and pulse peak_valid.
- Latency: if the last sample is accepted at edge k, peak_valid is high in the cycle after edge k+3 and peak outputs update on that same edge.
- An all-zero frame reports peak_bin=0, peak_pow=0; with SKIP_DC=1, bin 0 is reported only if every other bin is 0.
- A frame_err pulse and a peak_valid pulse can coincide, since the pipeline drains independently of the FSM.

Decomposition:
- Shared package fft_pkg: N_LOG2, DW, PW constants; FSM state encoding (IDLE, ACC); pipeline tag struct {valid, first, last, bin}.
- One sub-module, cplx_mag_sq: 2-stage registered |z|^2 (stages S1, S2) with pass-through tags.
- Top level holds the FSM, the counter and stage S3.

Test Plan:
- Single frame in natural order: bin 5 re=1000 im=0, all other bins 0 -> one peak_valid 3 cycles after the last bin, peak_bin=5, peak_pow=1000000, frame_err never pulses.
- Extreme values, bit-reversed order: bin 12 re=-32768 im=-32768, others small -> peak_bin=12, peak_pow=2147483648, no wrap.
- Tie and DC skip (SKIP_DC=1): bin 0 re=30000; bins 9 and 3 re=100, with 9 arriving first -> peak_bin=3, peak_pow=10000.
- Abort and stray input, with gaps inserted:
  - din_en with din_cnt=7 in IDLE -> frame_err pulses, sample dropped.
  - Later din_cnt=0 after 20 bins -> frame_err pulses; after 64 further bins, exactly one peak_valid.
- Back-to-back frames with no gap, peaks at bin 40 then bin 2 -> two peak_valid pulses 64 cycles apart, reporting 40 then 2, with correct powers.
- Reset: areset=1 at bin 30 of a frame -> outputs 0 next cycle, no peak_valid. Next full frame reports normally.
